// File: rtl/estado_temp_multi.sv
// Multi-channel temperature supervisor: per-channel NORMAL/BAJO/ALTO/ALERTA FSM with
// internal persistence counting, hysteresis on alert exit, and global alert aggregation.
module estado_temp_multi #(
   parameter int N_CANALES    = 4,
   parameter int ANCHO        = 11,
   parameter int TEMP_BAJO    = 180,
   parameter int TEMP_ALTO    = 259,
   parameter int HISTERESIS   = 4,
   parameter int PERSISTENCIA = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 muestra_valida,
   input  logic [N_CANALES*ANCHO-1:0]           temp_registrado,
   input  logic [N_CANALES-1:0]                 canal_habilitado,
   output logic [2*N_CANALES-1:0]               estado_actual,
   output logic [N_CANALES-1:0]                 alerta,
   output logic [N_CANALES-1:0]                 calefactor,
   output logic [N_CANALES-1:0]                 ventilador,
   output logic                                 alerta_global,
   output logic [$clog2(N_CANALES+1)-1:0]       num_alertas
);

   localparam int CW = $clog2(PERSISTENCIA + 1);
   localparam int NA = $clog2(N_CANALES + 1);

   localparam logic signed [ANCHO-1:0] T_BAJO = ANCHO'(TEMP_BAJO);
   localparam logic signed [ANCHO-1:0] T_ALTO = ANCHO'(TEMP_ALTO);
   localparam logic signed [ANCHO-1:0] REC_LO = ANCHO'(TEMP_BAJO + HISTERESIS);
   localparam logic signed [ANCHO-1:0] REC_HI = ANCHO'(TEMP_ALTO - HISTERESIS);
   localparam logic [CW-1:0]           CNT_LIM = CW'(PERSISTENCIA - 1);
   localparam logic [CW-1:0]           CNT_UNO = CW'(1);

   if (PERSISTENCIA < 2) begin : g_chk_pers
      $error("estado_temp_multi: PERSISTENCIA must be >= 2");
   end
   if (TEMP_BAJO + HISTERESIS > TEMP_ALTO - HISTERESIS) begin : g_chk_hist
      $error("estado_temp_multi: hysteresis band is empty");
   end

   typedef enum logic [1:0] {
      NORMAL = 2'b00,
      BAJO   = 2'b01,
      ALTO   = 2'b10,
      ALERTA = 2'b11
   } estado_t;

   for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
      estado_t                 state_q, state_d;
      logic [CW-1:0]           cnt_q, cnt_d;
      logic signed [ANCHO-1:0] ult_q, ult_d;
      logic signed [ANCHO-1:0] t;
      logic                    frio, caliente, recuperado;
      logic                    alerta_c, calef_c, vent_c;

      assign t          = temp_registrado[i*ANCHO +: ANCHO];
      assign frio       = (t < T_BAJO);
      assign caliente   = (t > T_ALTO);
      assign recuperado = (t >= REC_LO) && (t <= REC_HI);

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
            ult_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ult_q   <= ult_d;
         end
      end

      // A disabled channel is parked in NORMAL; otherwise only valid samples move it.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         ult_d   = ult_q;
         if (!canal_habilitado[i]) begin
            state_d = NORMAL;
            cnt_d   = '0;
            ult_d   = '0;
         end else begin
            if (muestra_valida) begin
               ult_d = t;
            end
            case (state_q)
               NORMAL: begin
                  if (muestra_valida) begin
                     if (frio) begin
                        state_d = BAJO;
                        cnt_d   = CNT_UNO;
                     end else if (caliente) begin
                        state_d = ALTO;
                        cnt_d   = CNT_UNO;
                     end else begin
                        cnt_d   = '0;
                     end
                  end
               end
               BAJO: begin
                  if (muestra_valida) begin
                     if (frio) begin
                        if (cnt_q == CNT_LIM) begin
                           state_d = ALERTA;
                           cnt_d   = '0;
                        end else begin
                           cnt_d   = cnt_q + CNT_UNO;
                        end
                     end else if (caliente) begin
                        state_d = ALTO;
                        cnt_d   = CNT_UNO;
                     end else begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                     end
                  end
               end
               ALTO: begin
                  if (muestra_valida) begin
                     if (caliente) begin
                        if (cnt_q == CNT_LIM) begin
                           state_d = ALERTA;
                           cnt_d   = '0;
                        end else begin
                           cnt_d   = cnt_q + CNT_UNO;
                        end
                     end else if (frio) begin
                        state_d = BAJO;
                        cnt_d   = CNT_UNO;
                     end else begin
                        state_d = NORMAL;
                        cnt_d   = '0;
                     end
                  end
               end
               ALERTA: begin
                  if (muestra_valida && recuperado) begin
                     state_d = NORMAL;
                     cnt_d   = '0;
                  end
               end
               default: begin
                  state_d = NORMAL;
                  cnt_d   = '0;
               end
            endcase
         end
      end

      // Outputs depend only on registered state and last sample, so they change on the clock edge.
      always_comb begin
         alerta_c = (state_q == ALERTA);
         calef_c  = alerta_c && (ult_q < T_BAJO);
         vent_c   = alerta_c && (ult_q > T_ALTO);
      end

      assign estado_actual[2*i +: 2] = state_q;
      assign alerta[i]               = alerta_c;
      assign calefactor[i]           = calef_c;
      assign ventilador[i]           = vent_c;
   end

   always_comb begin
      num_alertas = '0;
      for (int i = 0; i < N_CANALES; i++) begin
         num_alertas = num_alertas + NA'(alerta[i]);
      end
   end

   assign alerta_global = |alerta;

endmodule

// File: doc/estado_temp_multi.md
# estado_temp_multi

Multi-channel, parametrised temperature supervision FSM. It is the successor of the single-channel NORMAL/BAJO/ALTO/ALERTA monitor. Per channel, it adds:
- an internal persistence counter, replacing the external persistencia strobe;
- hysteresis on alert exit;
- a sample-valid qualifier;
- a channel enable.

It also aggregates all channels into global alert outputs. It sits after the per-sensor temperature registers and drives the heater/fan actuators and the alarm logic.

## Interface

Parameters:
- N_CANALES, 4, number of independent channels (>=1)
- ANCHO, 11, signed temperature width
- TEMP_BAJO, 180, lower limit; t < TEMP_BAJO is cold
- TEMP_ALTO, 259, upper limit; t > TEMP_ALTO is hot
- HISTERESIS, 4, exit margin from ALERTA; elaboration error unless TEMP_BAJO+HISTERESIS <= TEMP_ALTO-HISTERESIS
- PERSISTENCIA, 8, consecutive valid same-side out-of-range samples that raise ALERTA; elaboration error if < 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- muestra_valida  in  1  all channels present a new sample this cycle
- temp_registrado  in  N_CANALES*ANCHO  signed samples; channel i at [i*ANCHO +: ANCHO]
- canal_habilitado  in  N_CANALES  per-channel enable
- estado_actual  out  2*N_CANALES  per-channel state; channel i at [2i +: 2]; NORMAL=00, BAJO=01, ALTO=10, ALERTA=11
- alerta  out  N_CANALES  channel in ALERTA
- calefactor  out  N_CANALES  heater request
- ventilador  out  N_CANALES  fan request
- alerta_global  out  1  OR of alerta
- num_alertas  out  $clog2(N_CANALES+1)  popcount of alerta

## Operation

Definitions per channel, for sample t, compared signed:
- frio: t < TEMP_BAJO
- caliente: t > TEMP_ALTO
- en_rango: TEMP_BAJO <= t <= TEMP_ALTO
- recuperado: TEMP_BAJO+HISTERESIS <= t <= TEMP_ALTO-HISTERESIS

Per-channel state:
- 2-bit state
- persistence counter cnt, width $clog2(PERSISTENCIA+1)
- last valid sample ult

Update rules:
- The channel updates only on an edge where muestra_valida=1 and canal_habilitado[i]=1. On that edge ult <= t.
- NORMAL:
  - frio -> BAJO, cnt=1
  - caliente -> ALTO, cnt=1
  - en_rango: stay, cnt=0
- BAJO:
  - frio and cnt==PERSISTENCIA-1 -> ALERTA, cnt=0
  - frio otherwise: cnt+1, stay
  - caliente -> ALTO, cnt=1 (side switch restarts the count)
  - en_rango -> NORMAL, cnt=0
- ALTO: mirror of BAJO with frio and caliente swapped.
- ALERTA:
  - recuperado -> NORMAL, cnt=0
  - otherwise stay; in-range but not recuperado keeps ALERTA
- There is no direct ALERTA -> BAJO or ALERTA -> ALTO transition.
- Illegal state encoding -> NORMAL, cnt=0, on the next edge regardless of muestra_valida.

Disabled channel (canal_habilitado[i]=0):
- Next edge forces NORMAL, cnt=0, ult=0, all its outputs 0.
- It stays so while disabled.
- On re-enable it starts from NORMAL.

muestra_valida=0: every enabled channel holds state, cnt and ult.

Per-channel outputs, registered and updated on the same edge as the state:
- alerta = (state==ALERTA)
- calefactor = ALERTA and ult frio
- ventilador = ALERTA and ult caliente
- calefactor and ventilador are never both 1.
- In ALERTA with ult in range, both are 0.

Aggregates:
- alerta_global and num_alertas are combinational from the registered alerta vector.

## Timing

- Reset: on an edge with rst=1, every channel goes to NORMAL, cnt=0, ult=0. All outputs are 0 after that edge: estado_actual=0, alerta=0, calefactor=0, ventilador=0, alerta_global=0, num_alertas=0.
- rst overrides muestra_valida and canal_habilitado.
- Reset asserted mid-alert clears everything in one edge.
- Latency:
  - A valid sample at edge k is reflected in estado_actual, alerta, calefactor and ventilador immediately after edge k.
  - alerta_global and num_alertas follow in the same cycle, with zero added latency.
- ALERTA is reached after exactly PERSISTENCIA consecutive valid same-side samples, counting the NORMAL->BAJO or NORMAL->ALTO sample as sample 1. Invalid cycles between them do not break or advance the count.
- Channels are fully independent and update in parallel on the same edge.
- A disable and a valid sample on the same edge: disable wins.

## Test plan

1. **Reset:** rst=1 for 2 cycles during ALERTA on ch0 -> all outputs 0, estado_actual=0 after the first rst edge.
2. **Cold persistence** (PERSISTENCIA=8): ch0=150 valid for 7 samples -> estado BAJO, alerta=0. 8th sample -> ALERTA, calefactor[0]=1, ventilador[0]=0.
3. **Hysteresis** (HISTERESIS=4), ch0 in ALERTA from 300:
   - sample 260 -> ALERTA, ventilador=1
   - sample 257 -> ALERTA, ventilador=0
   - sample 255 -> NORMAL, alerta=0
4. **Valid gating:** during a cold run of 5 samples, hold muestra_valida=0 for 10 cycles with ch0=0 -> state and count unchanged. Alert is reached on the 3rd further valid cold sample.
5. **Side switch:** 5 valid samples at 150 then 1 at 300 -> ALTO, cnt=1. ALERTA requires 7 more samples at 300, not 3.
6. **Aggregation and disable:** ch1 and ch3 driven into ALERTA -> num_alertas=2, alerta_global=1. Clear canal_habilitado[1] -> after the next edge estado ch1=NORMAL, num_alertas=1, alerta_global=1.
